plot_receiver: RTL and testbench

Receiving end of the sprite/background drawers' plot interface (`plot`, `xCoord`, `yCoord`, `color`). Each plot strobe is one pixel. The block does three things with it:
- clips it against the 320x240 screen;
- converts (x,y) to a linear framebuffer address;
- buffers it in a small FIFO and writes it into video memory through a write port that can stall (`fb_ready` low while scanout owns the memory).

It sits between the drawer FSMs and the framebuffer RAM. It also reports idle and error status back to game-state logic.

---
 rtl/plot_receiver_pkg.sv | 25 ++
 rtl/plot_receiver_if.sv | 32 +++
 rtl/plot_receiver_pixel_fifo.sv | 59 +++++
 rtl/plot_receiver.sv | 81 ++++++++
 tb/tb_plot_receiver.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/plot_receiver_pkg.sv
// Shared screen geometry and pixel helpers used by drawers, scanout and the plot receiver.
package screen_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned COLOR_W   = 3;
  localparam int unsigned X_W       = 9;
  localparam int unsigned Y_W       = 8;

  // One buffered framebuffer write.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOR_W-1:0]   color;
  } pixel_t;

  // Linear address y*320 + x, built from shifts so no multiplier is inferred.
  function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                      input logic [Y_W-1:0] y);
    logic [FB_ADDR_W-1:0] y_ext;
    y_ext = FB_ADDR_W'(y);
    return (y_ext << 8) + (y_ext << 6) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_receiver_if.sv
// Drawer-side plot strobe, framebuffer write port and status flags of the plot receiver.
interface plot_receiver_if #(
  parameter int unsigned CNT_W = 8
);
  import screen_pkg::*;

  logic                 plot;
  logic [X_W-1:0]       xCoord;
  logic [Y_W-1:0]       yCoord;
  logic [COLOR_W-1:0]   color;
  logic                 fb_ready;
  logic                 fb_we;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [COLOR_W-1:0]   fb_data;
  logic                 idle;
  logic                 overflow;
  logic [CNT_W-1:0]     clipped_count;
  logic                 clear_flags;

  // Drawer / game-state / memory side.
  modport master (
    output plot, xCoord, yCoord, color, fb_ready, clear_flags,
    input  fb_we, fb_addr, fb_data, idle, overflow, clipped_count
  );

  // Plot receiver side.
  modport slave (
    input  plot, xCoord, yCoord, color, fb_ready, clear_flags,
    output fb_we, fb_addr, fb_data, idle, overflow, clipped_count
  );

endinterface

// File: rtl/plot_receiver_pixel_fifo.sv
// First-word fall-through synchronous FIFO for pending framebuffer writes.
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 20
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || pop);

  assign empty = (r_count == '0);
  assign full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/plot_receiver.sv
// Clips drawer pixels to the screen, converts them to linear addresses and queues them
// for a stallable framebuffer write port.
module plot_receiver
  import screen_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic             clock,
  input logic             reset,
  plot_receiver_if.slave  bus
);

  localparam int unsigned FIFO_W = FB_ADDR_W + COLOR_W;

  logic                   w_in_range;
  logic                   w_clip;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_empty;
  logic                   w_full;
  logic [$clog2(DEPTH):0] w_count;
  pixel_t                 w_wr_pix;
  pixel_t                 w_rd_pix;
  logic                   r_overflow;
  logic [CNT_W-1:0]       r_clipped_count;

  assign w_in_range = (bus.xCoord < X_W'(SCREEN_W)) && (bus.yCoord < Y_W'(SCREEN_H));
  assign w_clip     = bus.plot && !w_in_range;
  assign w_pop      = !w_empty && bus.fb_ready;
  assign w_push     = bus.plot && w_in_range && (!w_full || w_pop);
  assign w_drop     = bus.plot && w_in_range && w_full && !w_pop;

  assign w_wr_pix.addr  = pixel_addr(bus.xCoord, bus.yCoord);
  assign w_wr_pix.color = bus.color;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wr_pix),
    .rdata (w_rd_pix),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  // Write port follows the FIFO head; masked to zero while empty so uninitialised storage
  // never reaches the memory bus.
  always_comb begin
    bus.fb_we   = !w_empty;
    bus.fb_addr = w_empty ? '0 : w_rd_pix.addr;
    bus.fb_data = w_empty ? '0 : w_rd_pix.color;
    bus.idle    = w_empty;
  end

  // Sticky overflow and saturating clip counter; clear has priority over new events.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow      <= 1'b0;
      r_clipped_count <= '0;
    end else if (bus.clear_flags) begin
      r_overflow      <= 1'b0;
      r_clipped_count <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_clip && (r_clipped_count != {CNT_W{1'b1}})) begin
        r_clipped_count <= r_clipped_count + CNT_W'(1);
      end
    end
  end

  assign bus.overflow      = r_overflow;
  assign bus.clipped_count = r_clipped_count;

endmodule

// File: tb/tb_plot_receiver.sv
// Randomised and directed bench for plot_receiver against a queue-based reference model.
module tb_plot_receiver;
  import screen_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  plot_receiver_if #(.CNT_W(CNT_W)) pif ();

  plot_receiver #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (pif)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pending writes in strobe order plus the two status flags.
  int q_addr[$];
  int q_color[$];
  int m_clip = 0;
  bit m_ovf  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, act, act, exp,
               exp, $time);
    end
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_color.delete();
    m_clip = 0;
    m_ovf  = 1'b0;
  endtask

  // Applies the effect of one rising edge given the inputs currently on the bus.
  task automatic model_edge();
    bit inr, pop, acc, full;
    inr  = (int'(pif.xCoord) < 320) && (int'(pif.yCoord) < 240);
    full = (q_addr.size() == DEPTH);
    pop  = (q_addr.size() > 0) && pif.fb_ready;
    acc  = pif.plot && inr && (!full || pop);
    if (pop) begin
      void'(q_addr.pop_front());
      void'(q_color.pop_front());
    end
    if (acc) begin
      q_addr.push_back(int'(pif.yCoord) * 320 + int'(pif.xCoord));
      q_color.push_back(int'(pif.color));
    end
    if (pif.clear_flags) begin
      m_clip = 0;
      m_ovf  = 1'b0;
    end else begin
      if (pif.plot && !inr && m_clip < CNT_MAX) m_clip++;
      if (pif.plot && inr && !acc) m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit has = (q_addr.size() != 0);
    check_val("fb_we", pif.fb_we, has);
    check_val("fb_addr", pif.fb_addr, has ? q_addr[0] : 0);
    check_val("fb_data", pif.fb_data, has ? q_color[0] : 0);
    check_val("idle", pif.idle, !has);
    check_val("overflow", pif.overflow, m_ovf);
    check_val("clipped_count", pif.clipped_count, m_clip);
  endtask

  task automatic drive(input bit p, input int x, input int y, input int c, input bit rdy,
                       input bit clr);
    pif.plot        = p;
    pif.xCoord      = X_W'(x);
    pif.yCoord      = Y_W'(y);
    pif.color       = COLOR_W'(c);
    pif.fb_ready    = rdy;
    pif.clear_flags = clr;
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic tick();
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  // Drains with fb_ready high and no plots; returns the number of writes seen.
  task automatic drain(input int budget, output int writes);
    writes = 0;
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < budget && pif.fb_we; i++) begin
      writes++;
      tick();
    end
    check_val("drain_done", pif.idle, 1);
  endtask

  initial begin
    int n;
    int x, y;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clock);
    check_val("rst_fb_we", pif.fb_we, 0);
    check_val("rst_idle", pif.idle, 1);
    check_outputs();
    reset = 1'b0;

    // Single pixel.
    drive(1, 5, 2, 4, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check_val("single_we", pif.fb_we, 1);
    check_val("single_addr", pif.fb_addr, 645);
    check_val("single_data", pif.fb_data, 4);
    tick();
    check_val("single_idle", pif.idle, 1);

    // Corner and off-screen pixels.
    drive(1, 319, 239, 7, 1, 0);
    tick();
    check_val("corner_addr", pif.fb_addr, 76799);
    drive(1, 320, 0, 1, 1, 0);
    tick();
    drive(1, 0, 240, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    tick();
    check_val("clip_we", pif.fb_we, 0);
    check_val("clip_count2", pif.clipped_count, 2);

    // Stalled 4x4 sprite, one strobe every 4 cycles.
    for (int i = 0; i < 16; i++) begin
      drive(1, 100 + (i % 4), 50 + (i / 4), i % 8, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) tick();
    end
    check_val("stall_overflow", pif.overflow, 1);
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      check_val("burst_order", pif.fb_addr, (50 + i / 4) * 320 + 100 + (i % 4));
      tick();
    end
    check_val("burst_exact8", pif.fb_we, 0);

    // Push and pop in the same cycle while full.
    drive(0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 10, 2, 0, 0);
      tick();
    end
    drive(1, 9, 11, 5, 1, 0);
    tick();
    check_val("fullpp_overflow", pif.overflow, 0);
    check_val("fullpp_we", pif.fb_we, 1);
    drain(20, n);
    check_val("fullpp_count", n, 8);

    // Saturation, then clear with a simultaneous clip.
    for (int i = 0; i < 300; i++) begin
      drive(1, $urandom_range(320, 511), $urandom_range(0, 255), 0, 1, 0);
      tick();
    end
    check_val("sat_count", pif.clipped_count, CNT_MAX);
    drive(1, 400, 0, 0, 1, 1);
    tick();
    check_val("clear_count", pif.clipped_count, 0);
    check_val("clear_overflow", pif.overflow, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 319);
      y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 239);
      drive($urandom_range(0, 2) == 0, x, y, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 49) == 0);
      tick();
    end

    // Asynchronous reset with pending entries.
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drain(20, n);
    for (int i = 0; i < 3; i++) begin
      drive(1, 20 + i, 30, 6, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check_val("prerst_we", pif.fb_we, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_mid_we", pif.fb_we, 0);
    check_val("rst_mid_idle", pif.idle, 1);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    repeat (5) tick();
    check_val("no_stale_we", pif.fb_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
